rand_density_init: RTL and testbench

- Consumes the pseudorandom Q8.56 words from the LFSR stage.
- Maps each word to a perturbed initial density `Base + Amp*(2u-1)`, where `u` is the word's fractional part in [0,1).
- Streams one value per lattice node, with node address, over a valid/ready handshake to the lattice memory writer.
- Drives the LFSR's `Enable`, so the LFSR advances only when a sample is consumed; it watches the LFSR's completion flag to detect sequence wrap.

---
 rtl/lbm_fixed_pkg.sv | 30 +++
 rtl/fx_mul_shift.sv | 36 +++
 rtl/rand_density_init.sv | 131 +++++++++++++
 tb/tb_rand_density_init.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lbm_fixed_pkg.sv
// Q8.56 fixed-point constants, types and saturating helpers shared by the LBM datapath.
// The saturating helpers are only referenced when RAND_INIT_SATURATE_EN is defined.
package lbm_fixed_pkg;
  localparam int FRACTIONAL_BITS = 56;
  localparam int DATA_WIDTH      = 64;

  typedef logic signed [DATA_WIDTH-1:0]   fx_t;
  typedef logic signed [2*DATA_WIDTH-1:0] fx_wide_t;

  localparam fx_t ONE    = {{(DATA_WIDTH-FRACTIONAL_BITS-1){1'b0}}, 1'b1, {FRACTIONAL_BITS{1'b0}}};
  localparam fx_t FX_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam fx_t FX_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Overflow only happens when both operands share a sign that the sum loses.
  function automatic fx_t sat_add(input fx_t a, input fx_t b);
    fx_t s;
    s = a + b;
    if ((a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (s[DATA_WIDTH-1] != a[DATA_WIDTH-1]))
      s = a[DATA_WIDTH-1] ? FX_MIN : FX_MAX;
    return s;
  endfunction

  function automatic fx_t sat_narrow(input fx_wide_t x);
    fx_t r;
    r = x[DATA_WIDTH-1:0];
    if (x[2*DATA_WIDTH-1:DATA_WIDTH-1] != {(DATA_WIDTH+1){x[2*DATA_WIDTH-1]}})
      r = x[2*DATA_WIDTH-1] ? FX_MIN : FX_MAX;
    return r;
  endfunction
endpackage

// File: rtl/fx_mul_shift.sv
// Registered signed Q8.56 multiply with floor shift back to Q8.56.
// RAND_INIT_SATURATE_EN selects saturating narrowing; otherwise the result wraps.
module fx_mul_shift
  import lbm_fixed_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] y
);
  fx_wide_t a_x, b_x, prod, shifted;

  always_comb begin
    a_x     = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
    b_x     = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
    prod    = a_x * b_x;
    shifted = prod >>> FRACTIONAL_BITS;
  end

`ifdef RAND_INIT_SATURATE_EN
  always_ff @(posedge clk) begin
    if (reset)   y <= '0;
    else if (en) y <= sat_narrow(shifted);
  end
`else
  logic unused_hi;
  assign unused_hi = ^shifted[2*DATA_WIDTH-1:DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (reset)   y <= '0;
    else if (en) y <= shifted[DATA_WIDTH-1:0];
  end
`endif
endmodule

// File: rtl/rand_density_init.sv
// Maps LFSR words to Base + Amp*(2u-1) densities, one per lattice node, over valid/ready.
// RAND_INIT_SATURATE_EN makes the scaling and the final sum saturate instead of wrap.
module rand_density_init #(
  parameter int FRACTIONAL_BITS = 56,
  parameter int DATA_WIDTH      = 64,
  parameter int NUM_NODES       = 1024,
  parameter int ADDR_W          = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [DATA_WIDTH-1:0] Base,
  input  logic [DATA_WIDTH-1:0] Amp,
  input  logic [DATA_WIDTH-1:0] Rand_In,
  input  logic                  Rand_Wrap,
  output logic                  Lfsr_Enable,
  output logic                  Dout_Valid,
  input  logic                  Dout_Ready,
  output logic [DATA_WIDTH-1:0] Dout,
  output logic [ADDR_W-1:0]     Addr,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Wrap_Err
);
  import lbm_fixed_pkg::*;

  localparam int               CNT_W = $clog2(NUM_NODES + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_NODES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        issued, accepted;
  logic [ADDR_W-1:0]       load_idx;
  logic [DATA_WIDTH-1:0]   base_q, amp_q, s1, s2, sum;
  logic                    s1_v, s2_v;
  logic                    stall, advance, xfer;
  logic                    unused_int;

  // Handshake: a word moves on Dout_Valid && Dout_Ready; a waiting word freezes the whole pipe.
  assign stall       = Dout_Valid && !Dout_Ready;
  assign advance     = !stall;
  assign xfer        = Dout_Valid && Dout_Ready;
  assign Lfsr_Enable = (state == S_RUN) && (issued < LAST) && !stall;
  assign unused_int  = ^Rand_In[DATA_WIDTH-1:FRACTIONAL_BITS];

`ifdef RAND_INIT_SATURATE_EN
  assign sum = sat_add(base_q, s2);
`else
  assign sum = base_q + s2;
`endif

  fx_mul_shift u_mul (
    .clk   (Clk),
    .reset (Reset),
    .en    (advance),
    .a     (amp_q),
    .b     (s1),
    .y     (s2)
  );

  // Stage 1 forms s = 2u - ONE from the fraction; stage 3 registers the sum with its node index.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1         <= '0;
      s1_v       <= 1'b0;
      s2_v       <= 1'b0;
      Dout_Valid <= 1'b0;
      Dout       <= '0;
      Addr       <= '0;
    end else if (advance) begin
      s1_v       <= Lfsr_Enable;
      s2_v       <= s1_v;
      Dout_Valid <= s2_v;
      if (Lfsr_Enable)
        s1 <= {{(DATA_WIDTH-FRACTIONAL_BITS-1){1'b0}}, Rand_In[FRACTIONAL_BITS-1:0], 1'b0} - ONE;
      if (s2_v) begin
        Dout <= sum;
        Addr <= load_idx;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Wrap_Err <= 1'b0;
      issued   <= '0;
      accepted <= '0;
      load_idx <= '0;
      base_q   <= '0;
      amp_q    <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            state    <= S_RUN;
            Busy     <= 1'b1;
            base_q   <= Base;
            amp_q    <= Amp;
            issued   <= '0;
            accepted <= '0;
            load_idx <= '0;
            Wrap_Err <= 1'b0;
          end
        end
        S_RUN: begin
          if (Lfsr_Enable) begin
            issued <= issued + 1'b1;
            // The LFSR flags completion on the first word of a fresh period; only later wraps matter.
            if (Rand_Wrap && (issued != '0)) Wrap_Err <= 1'b1;
          end
          if (advance && s2_v) load_idx <= load_idx + 1'b1;
          if (xfer) begin
            accepted <= accepted + 1'b1;
            if (accepted == LAST - 1'b1) begin
              state <= S_DONE;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rand_density_init.sv
// Randomized scoreboard bench for rand_density_init with a 4-node run length.
// Expected densities come from a wide-integer model of Base + floor(Amp*(2u-1)).
module tb_rand_density_init;
  localparam int DW = 64;
  localparam int FB = 56;
  localparam int N  = 4;
  localparam int AW = 2;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic [DW-1:0] Base = '0;
  logic [DW-1:0] Amp = '0;
  logic [DW-1:0] Rand_In = '0;
  logic          Rand_Wrap = 1'b0;
  logic          Dout_Ready = 1'b0;
  logic          Lfsr_Enable, Dout_Valid, Busy, Done, Wrap_Err;
  logic [DW-1:0] Dout;
  logic [AW-1:0] Addr;

  rand_density_init #(
    .FRACTIONAL_BITS (FB),
    .DATA_WIDTH      (DW),
    .NUM_NODES       (N),
    .ADDR_W          (AW)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .Base        (Base),
    .Amp         (Amp),
    .Rand_In     (Rand_In),
    .Rand_Wrap   (Rand_Wrap),
    .Lfsr_Enable (Lfsr_Enable),
    .Dout_Valid  (Dout_Valid),
    .Dout_Ready  (Dout_Ready),
    .Dout        (Dout),
    .Addr        (Addr),
    .Busy        (Busy),
    .Done        (Done),
    .Wrap_Err    (Wrap_Err)
  );

  // clock
  always #5 Clk = ~Clk;

  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] base_m = '0, amp_m = '0, dir_exp = '0, rand_fixed = '0;
  logic          dir_mode = 1'b0, rand_mode = 1'b0, wrap_test = 1'b0;
  logic          wrap_m = 1'b0, done_due = 1'b0, run_done = 1'b0, hold_v = 1'b0;
  logic [DW-1:0] hold_d = '0;
  logic [AW-1:0] hold_a = '0;
  int            n_enable = 0, n_xfer = 0, cyc = 0, ready_mode = 0;

  localparam logic signed [127:0] MAX128 = 128'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [127:0] MIN128 = -128'sh8000_0000_0000_0000;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic signed [127:0] clamp(input logic signed [127:0] x);
    if (x > MAX128) return MAX128;
    if (x < MIN128) return MIN128;
    return x;
  endfunction

  // Reference: u = fraction/2^56, result = Base + floor(Amp*(2u-1)) in exact wide arithmetic.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] r, input logic [DW-1:0] base,
                                          input logic [DW-1:0] amp);
    logic signed [127:0] u, s, a, b, scaled, total;
    u         = '0;
    u[FB-1:0] = r[FB-1:0];
    s         = 2 * u - (128'sd1 <<< FB);
    a         = $signed(amp);
    b         = $signed(base);
    scaled    = (a * s) >>> FB;
`ifdef RAND_INIT_SATURATE_EN
    scaled = clamp(scaled);
    total  = clamp(b + scaled);
`else
    total  = b + scaled;
`endif
    return total[DW-1:0];
  endfunction

  // scoreboard monitor: samples mid-cycle what the next rising edge will do
  always @(negedge Clk) begin
    if (!Reset) begin
      if (done_due) begin
        chk("done_pulse", DW'(Done), DW'(1'b1));
        chk("busy_at_done", DW'(Busy), DW'(1'b0));
        done_due = 1'b0;
        run_done = 1'b1;
      end else if (Done) begin
        chk("done_spurious", DW'(Done), DW'(1'b0));
      end
      if (hold_v) begin
        chk("stall_valid", DW'(Dout_Valid), DW'(1'b1));
        chk("stall_dout", Dout, hold_d);
        chk("stall_addr", DW'(Addr), DW'(hold_a));
      end
      hold_v = Dout_Valid && !Dout_Ready;
      hold_d = Dout;
      hold_a = Addr;
      if (Lfsr_Enable) begin
        n_enable++;
        if (Rand_Wrap && n_enable > 1) wrap_m = 1'b1;
        exp_q.push_back(dir_mode ? dir_exp : model(Rand_In, base_m, amp_m));
      end
      if (Dout_Valid && Dout_Ready) begin
        chk("busy_in_run", DW'(Busy), DW'(1'b1));
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got %h, expected no word", Dout);
        end else begin
          chk("dout", Dout, exp_q.pop_front());
        end
        chk("addr", DW'(Addr), DW'(n_xfer));
        n_xfer++;
        if (n_xfer == N) done_due = 1'b1;
      end
    end
  end

  // driver: inputs change just after the rising edge
  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
    case (ready_mode)
      0:       Dout_Ready = 1'b1;
      1:       Dout_Ready = 1'($urandom_range(0, 1));
      default: Dout_Ready = (cyc % 3 == 1);
    endcase
    Rand_In   = rand_mode ? rand_fixed : {$urandom, $urandom};
    Rand_Wrap = wrap_test ? (n_enable == 2) : (n_enable == 0);
  endtask

  task automatic begin_run(input logic [DW-1:0] base, input logic [DW-1:0] amp, input int rmode);
    exp_q.delete();
    base_m = base; amp_m = amp;
    n_enable = 0; n_xfer = 0; wrap_m = 1'b0; run_done = 1'b0;
    ready_mode = rmode; cyc = 0;
    Base = base; Amp = amp; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("busy_after_start", DW'(Busy), DW'(1'b1));
    chk("enable_after_start", DW'(Lfsr_Enable), DW'(1'b1));
    chk("wrap_cleared", DW'(Wrap_Err), DW'(1'b0));
  endtask

  task automatic do_run(input logic [DW-1:0] base, input logic [DW-1:0] amp, input int rmode,
                        input bit start_mid, input bit start_on_done);
    begin_run(base, amp, rmode);
    for (int i = 0; i < 400 && !run_done; i++) begin
      tick();
      Start = start_mid && (i == 3);
      if (Start) begin
        Base = {$urandom, $urandom};
        Amp  = {$urandom, $urandom};
      end
      if (start_on_done && Done) begin
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("start_on_done_ignored", DW'(Busy), DW'(1'b0));
      end
    end
    Start = 1'b0;
    if (!run_done) begin
      vectors++;
      miscompares++;
      $display("FAIL run_timeout: got %0d transfers, expected %0d", n_xfer, N);
    end
    chk("enable_count", DW'(n_enable), DW'(N));
    chk("leftover_expected", DW'(exp_q.size()), DW'(0));
    chk("wrap_err", DW'(Wrap_Err), DW'(wrap_m));
    chk("busy_idle", DW'(Busy), DW'(1'b0));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_enable"}, DW'(Lfsr_Enable), DW'(1'b0));
    chk({tag, "_valid"}, DW'(Dout_Valid), DW'(1'b0));
    chk({tag, "_dout"}, Dout, '0);
    chk({tag, "_addr"}, DW'(Addr), DW'(0));
    chk({tag, "_busy"}, DW'(Busy), DW'(1'b0));
    chk({tag, "_done"}, DW'(Done), DW'(1'b0));
    chk({tag, "_wrap"}, DW'(Wrap_Err), DW'(1'b0));
  endtask

  initial begin
    Reset = 1'b1;
    repeat (3) tick();
    check_reset_values("reset");
    Reset = 1'b0;
    tick();

    // directed values with known results
    dir_mode = 1'b1; rand_mode = 1'b1;
    rand_fixed = 64'h0000_0000_0000_0000; dir_exp = 64'h00C0_0000_0000_0000;
    do_run(64'h0100_0000_0000_0000, 64'h0040_0000_0000_0000, 0, 1'b0, 1'b0);
    rand_fixed = 64'h0080_0000_0000_0000; dir_exp = 64'h0100_0000_0000_0000;
    do_run(64'h0100_0000_0000_0000, 64'h0040_0000_0000_0000, 1, 1'b0, 1'b0);
    rand_fixed = 64'hFF80_0000_0000_0000; dir_exp = 64'h0100_0000_0000_0000;
    do_run(64'h0100_0000_0000_0000, 64'h0040_0000_0000_0000, 2, 1'b0, 1'b1);
    rand_fixed = 64'h00FF_FFFF_FFFF_FFFF;
`ifdef RAND_INIT_SATURATE_EN
    dir_exp = 64'h7FFF_FFFF_FFFF_FFFF;
`else
    dir_exp = 64'hFDFF_FFFF_FFFF_FF02;
`endif
    do_run(64'h7F00_0000_0000_0000, 64'h7F00_0000_0000_0000, 0, 1'b0, 1'b0);

    // wrap on the third capture, sticky until the next start
    dir_mode = 1'b0; rand_mode = 1'b0; wrap_test = 1'b1;
    do_run({$urandom, $urandom}, {$urandom, $urandom}, 2, 1'b0, 1'b0);
    chk("wrap_set", DW'(Wrap_Err), DW'(1'b1));
    wrap_test = 1'b0;
    repeat (5) tick();
    chk("wrap_sticky", DW'(Wrap_Err), DW'(1'b1));

    // random operands, ready patterns and ignored mid-run starts
    for (int k = 0; k < 8; k++)
      do_run({$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 2), k[0], 1'b0);

    // reset after two transfers, then a clean run
    begin_run({$urandom, $urandom}, {$urandom, $urandom}, 1);
    for (int i = 0; i < 200 && n_xfer < 2; i++) tick();
    Reset = 1'b1;
    tick();
    check_reset_values("midreset");
    Reset = 1'b0;
    exp_q.delete();
    hold_v = 1'b0; done_due = 1'b0;
    tick();
    do_run({$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
